// File: rtl/nibble_packer.sv
// nibble_packer
// Packs NIBBLES consecutive WIDTH-bit nibbles into one word and presents it on
// a registered valid/ready output. Nibble k of a word sits at
// bits [k*WIDTH +: WIDTH]. A closed word that cannot reach the output yet waits
// in the packing register, and while it waits the input is stalled.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - synchronous active-high reset
//   clear      - synchronous flush-and-discard, same effect as reset
//   in_data    - incoming nibble
//   in_valid   - in_data valid this cycle
//   in_ready   - block accepts in_data this cycle (state-only, no in_valid path)
//   flush      - close the current partial word early, zero-padding the rest
//   out_word   - packed word
//   out_count  - number of valid nibbles in out_word (1..NIBBLES)
//   out_valid  - out_word/out_count valid
//   out_ready  - consumer takes the word this cycle
module nibble_packer #(
    parameter int NIBBLES = 8,
    parameter int WIDTH   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [NIBBLES*WIDTH-1:0]     out_word,
    output logic [$clog2(NIBBLES):0]     out_count,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int IW = $clog2(NIBBLES);
    localparam int CW = IW + 1;
    localparam int DW = NIBBLES * WIDTH;

    logic [DW-1:0] pack;
    logic [IW-1:0] idx;
    logic          pack_full;
    logic [CW-1:0] held_count;

    logic          xfer;
    logic          out_free;
    logic          close;
    logic [DW-1:0] pack_next;
    logic [CW-1:0] cnt_next;

    assign in_ready = !pack_full;
    assign xfer     = in_valid && in_ready;
    // The output slot can take a new word if empty or being drained this edge.
    assign out_free = !out_valid || out_ready;

    always_comb begin
        pack_next = pack;
        for (int k = 0; k < NIBBLES; k++) begin
            if (xfer && idx == IW'(k)) begin
                pack_next[k*WIDTH +: WIDTH] = in_data;
            end
        end
    end

    // Count includes a nibble accepted in the same cycle as the close.
    assign cnt_next = {1'b0, idx} + CW'(xfer);

    // A held word is already closed, so nothing new can close while pack_full.
    // A flush with nothing written (cnt_next == 0) never produces a word.
    assign close = !pack_full &&
                   ((xfer && idx == IW'(NIBBLES-1)) || (flush && cnt_next != '0));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pack       <= '0;
            idx        <= '0;
            pack_full  <= 1'b0;
            held_count <= '0;
            out_word   <= '0;
            out_count  <= '0;
            out_valid  <= 1'b0;
        end else if (pack_full) begin
            // Waiting word moves out as soon as the output slot frees up.
            if (out_free) begin
                out_word   <= pack;
                out_count  <= held_count;
                out_valid  <= 1'b1;
                pack       <= '0;
                pack_full  <= 1'b0;
                idx        <= '0;
            end
        end else if (close) begin
            idx <= '0;
            if (out_free) begin
                out_word  <= pack_next;
                out_count <= cnt_next;
                out_valid <= 1'b1;
                pack      <= '0;
            end else begin
                pack       <= pack_next;
                held_count <= cnt_next;
                pack_full  <= 1'b1;
            end
        end else begin
            pack <= pack_next;
            if (xfer) begin
                idx <= idx + 1'b1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_nibble_packer;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int DW = N * W;
    localparam int CW = $clog2(N) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [DW-1:0] out_word;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    nibble_packer #(.NIBBLES(N), .WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_word  (out_word),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [W-1:0]  cur[$];
    bit            m_held;
    logic [DW-1:0] m_hw;
    int            m_hc;
    bit            m_ov;
    logic [DW-1:0] m_ow;
    int            m_oc;

    function automatic logic [DW-1:0] build_word(input logic [W-1:0] q[$]);
        logic [DW-1:0] w;
        w = '0;
        foreach (q[k]) w = w | (DW'(q[k]) << (k * W));
        return w;
    endfunction

    always @(posedge clock) begin
        bit free;
        logic [DW-1:0] w;
        int c;
        if (reset || clear) begin
            cur.delete();
            m_held = 0; m_ov = 0; m_ow = '0; m_oc = 0;
            started = 1;
        end else begin
            free = !m_ov || out_ready;
            if (m_held) begin
                if (free) begin
                    m_ov = 1; m_ow = m_hw; m_oc = m_hc; m_held = 0;
                end
            end else begin
                if (in_valid) cur.push_back(in_data);
                if (cur.size() == N || (flush && cur.size() > 0)) begin
                    w = build_word(cur);
                    c = cur.size();
                    cur.delete();
                    if (free) begin
                        m_ov = 1; m_ow = w; m_oc = c;
                    end else begin
                        m_held = 1; m_hw = w; m_hc = c;
                    end
                end else if (m_ov && out_ready) begin
                    m_ov = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (started) begin
            total++;
            if (out_valid !== m_ov) begin
                bad++;
                $display("FAIL model_out_valid t=%0t got=%0b want=%0b", $time, out_valid, m_ov);
            end
            total++;
            if (in_ready !== !m_held) begin
                bad++;
                $display("FAIL model_in_ready t=%0t got=%0b want=%0b", $time, in_ready, !m_held);
            end
            if (m_ov) begin
                total++;
                if (out_word !== m_ow || out_count !== CW'(m_oc)) begin
                    bad++;
                    $display("FAIL model_word t=%0t got=%h/%0d want=%h/%0d",
                             $time, out_word, out_count, m_ow, m_oc);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit fl);
        in_valid = v;
        in_data  = d;
        flush    = fl;
        @(posedge clock);
        #1;
        in_valid = 0;
        flush    = 0;
    endtask

    int pulses;

    initial begin
        // 1: reset, then 1..8 streaming
        out_ready = 1;
        reset = 1; step(0, 0, 0); reset = 0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_count", 64'(out_count), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            step(1, W'(i), 0);
            check("t1_in_ready", 64'(in_ready), 64'd1);
            if (i < 8) check("t1_no_early_valid", 64'(out_valid), 64'd0);
        end
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_word", 64'(out_word), 64'h87654321);
        check("t1_count", 64'(out_count), 64'd8);

        // 2: partial word via flush, then empty flush
        step(1, 4'hA, 0); step(1, 4'hB, 0); step(1, 4'hC, 0);
        step(0, 0, 1);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_word", 64'(out_word), 64'h00000CBA);
        check("t2_count", 64'(out_count), 64'd3);
        step(0, 0, 1);
        check("t2_empty_flush", 64'(out_valid), 64'd0);
        check("t2_word_hold", 64'(out_word), 64'h00000CBA);

        // 3: backpressure, held word, release
        out_ready = 0;
        for (int i = 0; i < 16; i++) step(1, W'(i), 0);
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        check("t3_first_word", 64'(out_word), 64'h76543210);
        check("t3_valid", 64'(out_valid), 64'd1);
        out_ready = 1; step(0, 0, 0); out_ready = 0;
        check("t3_second_word", 64'(out_word), 64'hFEDCBA98);
        check("t3_valid2", 64'(out_valid), 64'd1);
        check("t3_in_ready", 64'(in_ready), 64'd1);
        check("t3_count", 64'(out_count), 64'd8);
        out_ready = 1; step(0, 0, 0);
        check("t3_drained", 64'(out_valid), 64'd0);

        // 4: continuous streaming, 4 words
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step(1, W'(i * 7 + 3), 0);
            check("t4_in_ready", 64'(in_ready), 64'd1);
            if (out_valid) pulses++;
        end
        check("t4_words", 64'(pulses), 64'd4);
        // last word: nibbles i=24..31 of (7i+3)&F = B,2,9,0,7,E,5,C
        check("t4_last_word", 64'(out_word), 64'hC5E7092B);
        step(0, 0, 0);

        // 5: clear from held state with in_valid high
        out_ready = 0;
        for (int i = 0; i < 16; i++) step(1, W'(i ^ 5), 0);
        check("t5_held", 64'(in_ready), 64'd0);
        clear = 1; step(1, 4'h9, 0); clear = 0;
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1;
        for (int i = 1; i <= 8; i++) step(1, W'(i), 0);
        check("t5_word", 64'(out_word), 64'h87654321);

        // 6: reset mid-word
        for (int i = 0; i < 5; i++) step(1, 4'hF, 0);
        reset = 1; step(1, 4'hE, 0); reset = 0;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        for (int i = 1; i <= 7; i++) step(1, W'(i), 0);
        step(1, 4'h8, 1);  // flush with the last-slot fill: one full word
        check("t6_word", 64'(out_word), 64'h87654321);
        check("t6_count", 64'(out_count), 64'd8);
        step(0, 0, 0);
        check("t6_single_word", 64'(out_valid), 64'd0);

        // single nibble with same-cycle flush
        step(1, 4'h6, 1);
        check("t7_word", 64'(out_word), 64'h00000006);
        check("t7_count", 64'(out_count), 64'd1);
        step(0, 0, 0);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
